health_ctrl: RTL and testbench
==============================

HEALTH_CTRL -- requirements
Module: health_ctrl

Interface
REQ-001 Parameter MAX_LIVES, default 3: number of hearts; legal range 1..7.
REQ-002 Parameter SHIELD_FRAMES, default 300: shield duration in frames, at least 1.
REQ-003 Parameter INVULN_FRAMES, default 60: post-hit invulnerability in frames, at least 1.
REQ-004 Parameter BLINK_FRAMES, default 8: half-period of the heart blink in frames, at least 1.
REQ-005 clk  in  1  pixel clock, 65 MHz.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 game_en  in  1  high while a round is in play.
REQ-008 vsync  in  1  vga_if vsync of the timing chain; a frame tick is each falling edge.
REQ-009 hit  in  1  single-cycle damage pulse.
REQ-010 heal  in  1  single-cycle extra-life pickup pulse.
REQ-011 shield_pickup  in  1  single-cycle umbrella pickup pulse.
REQ-012 lives  out  3  current life count.
REQ-013 heart_en  out  MAX_LIVES  per-heart enable; bit i drives health_en of draw_health instance i.
REQ-014 is_shielded  out  1  drives is_shielded of every draw_health instance.
REQ-015 game_over  out  1  high while in the DEAD state.

Function
REQ-016 The block SHALL keep one FSM with states IDLE, ALIVE, INVULN, SHIELDED and DEAD.
REQ-017 IDLE→ALIVE SHALL occur on the cycle game_en is high, and lives SHALL load MAX_LIVES.
REQ-018 game_en low in any state SHALL force IDLE on the next edge and clear all counters.
REQ-019 In ALIVE, hit SHALL decrement lives.
  - lives reaching 0 → DEAD.
  - otherwise → INVULN, with the frame counter loaded to INVULN_FRAMES.
REQ-020 In INVULN and SHIELDED, hit SHALL be ignored.
REQ-021 In ALIVE or INVULN, shield_pickup SHALL enter SHIELDED with the counter loaded to SHIELD_FRAMES.
REQ-022 In SHIELDED, shield_pickup SHALL reload the counter to SHIELD_FRAMES.
REQ-023 heal SHALL increment lives in ALIVE, INVULN and SHIELDED, saturating at MAX_LIVES.
REQ-024 The frame tick SHALL be one cycle, asserted on the cycle after vsync is sampled falling; the block SHALL register vsync for edge detection.
REQ-025 In INVULN and SHIELDED, each tick SHALL decrement the counter.
  - Decrementing from 1 to 0 → ALIVE on that cycle.
REQ-026 When hit and shield_pickup coincide in ALIVE, shield_pickup SHALL win and no life SHALL be lost.
REQ-027 When hit and heal coincide in ALIVE, lives SHALL be unchanged and the FSM SHALL enter INVULN.
REQ-028 When a tick coincides with a pickup, the counter reload SHALL win over the decrement.
REQ-029 DEAD SHALL ignore hit, heal and shield_pickup, and SHALL leave only through game_en low.
REQ-030 heart_en[i] SHALL equal (i < lives), gated by game_en; is_shielded SHALL be high only in SHIELDED.
REQ-031 Outputs SHALL be registered: one-cycle latency from an input pulse to lives, heart_en and is_shielded.

Reset
REQ-032 With rst low, the block SHALL set state=IDLE, lives=0, heart_en=0, is_shielded=0 and game_over=0 immediately, with no clock required.
REQ-033 With rst low, the frame counter, blink counter and vsync register SHALL clear; vsync_q SHALL clear to 1 so that no spurious tick occurs.
REQ-034 Release of rst mid-frame SHALL produce no tick before the next real vsync falling edge.

Configuration
REQ-035 With HEALTH_BLINK_EN defined, heart_en SHALL toggle in INVULN every BLINK_FRAMES ticks.
  - The first toggle blanks the hearts.
  - A dedicated blink counter restarts on INVULN entry.
  - The mask clears on INVULN exit.
REQ-036 Without HEALTH_BLINK_EN, heart_en SHALL be steady in INVULN and no blink counter SHALL be synthesised.

Verification
REQ-037 Scenario 1: rst low, then high with game_en=1 → lives=3, heart_en=3'b111 one cycle later; game_over=0.
REQ-038 Scenario 2: hit in ALIVE → lives=2, heart_en=3'b011, state INVULN.
  - A second hit 10 frames later is ignored.
  - ALIVE is re-entered after tick 60.
REQ-039 Scenario 3: three hits spaced more than 60 frames apart → lives=0, game_over=1.
  - heal then has no effect.
  - game_en low → IDLE, game_over=0.
REQ-040 Scenario 4: shield_pickup → is_shielded=1 for exactly 300 ticks.
  - hit during the shield leaves lives=3.
  - shield_pickup at tick 299 extends the shield by 300 more.
REQ-041 Scenario 5: lives=3 plus heal → lives stays 3; hit and shield_pickup on the same cycle → lives=3, is_shielded=1.
REQ-042 Scenario 6: with HEALTH_BLINK_EN, after a hit heart_en reads 0 for ticks 8-15 and 3'b011 for ticks 16-23; without the macro it reads 3'b011 throughout.

Source files
------------

// File: rtl/health_ctrl.sv
// Player health FSM: lives, post-hit invulnerability and shield timing, counted in vsync frames.
// Optional HEALTH_BLINK_EN build flag blinks the hearts while invulnerable.
module health_ctrl #(
  parameter int MAX_LIVES     = 3,
  parameter int SHIELD_FRAMES = 300,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 game_en,
  input  logic                 vsync,
  input  logic                 hit,
  input  logic                 heal,
  input  logic                 shield_pickup,
  output logic [2:0]           lives,
  output logic [MAX_LIVES-1:0] heart_en,
  output logic                 is_shielded,
  output logic                 game_over
);

  localparam int CNT_MAX = (SHIELD_FRAMES > INVULN_FRAMES) ? SHIELD_FRAMES : INVULN_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [2:0]       LIVES_MAX   = 3'(MAX_LIVES);
  localparam logic [CNT_W-1:0] SHIELD_LOAD = CNT_W'(SHIELD_FRAMES);
  localparam logic [CNT_W-1:0] INVULN_LOAD = CNT_W'(INVULN_FRAMES);

  if (MAX_LIVES < 1 || MAX_LIVES > 7 || SHIELD_FRAMES < 1 || INVULN_FRAMES < 1 || BLINK_FRAMES < 1)
  begin : g_bad_param
    $error("health_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, ALIVE, INVULN, SHIELDED, DEAD} state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [2:0]           lives_nx;
  logic                 vsync_q, tick;
  logic                 blank_nx;
  logic [MAX_LIVES-1:0] hearts_nx;

  function automatic logic [2:0] heal_sat(input logic [2:0] l);
    return (l >= LIVES_MAX) ? LIVES_MAX : l + 3'd1;
  endfunction

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lives_nx = lives;
    if (!game_en) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      lives_nx = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = ALIVE;
          lives_nx = LIVES_MAX;
          cnt_nx   = '0;
        end
        ALIVE: begin
          // Shield beats a same-cycle hit; a same-cycle heal cancels the hit's life loss.
          if (shield_pickup) begin
            state_nx = SHIELDED;
            cnt_nx   = SHIELD_LOAD;
            if (heal) lives_nx = heal_sat(lives);
          end else if (hit && heal) begin
            state_nx = INVULN;
            cnt_nx   = INVULN_LOAD;
          end else if (hit) begin
            if (lives <= 3'd1) begin
              state_nx = DEAD;
              lives_nx = 3'd0;
              cnt_nx   = '0;
            end else begin
              state_nx = INVULN;
              lives_nx = lives - 3'd1;
              cnt_nx   = INVULN_LOAD;
            end
          end else if (heal) begin
            lives_nx = heal_sat(lives);
          end
        end
        INVULN, SHIELDED: begin
          if (heal) lives_nx = heal_sat(lives);
          if (shield_pickup) begin
            state_nx = SHIELDED;
            cnt_nx   = SHIELD_LOAD;
          end else if (tick) begin
            if (cnt <= CNT_W'(1)) begin
              state_nx = ALIVE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt - CNT_W'(1);
            end
          end
        end
        DEAD: ;
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef HEALTH_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [BW-1:0] blink_cnt, blink_cnt_nx;
  logic          blink_mask, blink_mask_nx;

  // Blink phase restarts on every INVULN entry and is dropped on exit.
  always_comb begin
    blink_cnt_nx  = blink_cnt;
    blink_mask_nx = blink_mask;
    if (state_nx != INVULN || state != INVULN) begin
      blink_cnt_nx  = '0;
      blink_mask_nx = 1'b0;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_nx  = '0;
        blink_mask_nx = ~blink_mask;
      end else begin
        blink_cnt_nx = blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt  <= '0;
      blink_mask <= 1'b0;
    end else begin
      blink_cnt  <= blink_cnt_nx;
      blink_mask <= blink_mask_nx;
    end
  end

  assign blank_nx = blink_mask_nx;
`else
  assign blank_nx = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < MAX_LIVES; i++)
      hearts_nx[i] = game_en && !blank_nx && (3'(i) < lives_nx);
  end

  // vsync_q idles high so reset release never manufactures a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lives       <= 3'd0;
      vsync_q     <= 1'b1;
      tick        <= 1'b0;
      heart_en    <= '0;
      is_shielded <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      tick        <= vsync_q & ~vsync;
      state       <= state_nx;
      cnt         <= cnt_nx;
      lives       <= lives_nx;
      heart_en    <= hearts_nx;
      is_shielded <= (state_nx == SHIELDED);
      game_over   <= (state_nx == DEAD);
    end
  end

endmodule

// File: tb/tb_health_ctrl.sv
// Directed bench for health_ctrl with default parameters (3 lives, 300/60/8 frames).
module tb_health_ctrl;

  logic       clk = 1'b0;
  logic       rst, game_en, vsync, hit, heal, shield_pickup;
  logic [2:0] lives;
  logic [2:0] heart_en;
  logic       is_shielded, game_over;
  int         total = 0;
  int         bad   = 0;

`ifdef HEALTH_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  health_ctrl dut (
    .clk(clk), .rst(rst), .game_en(game_en), .vsync(vsync), .hit(hit), .heal(heal),
    .shield_pickup(shield_pickup), .lives(lives), .heart_en(heart_en),
    .is_shielded(is_shielded), .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse(input logic h, input logic he, input logic sh);
    @(negedge clk);
    hit = h; heal = he; shield_pickup = sh;
    @(negedge clk);
    hit = 1'b0; heal = 1'b0; shield_pickup = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) vsync = 1'b0;
      @(negedge clk) vsync = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; game_en = 1'b1; vsync = 1'b1; hit = 1'b0; heal = 1'b0; shield_pickup = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (lives !== 3'd0) begin bad++; $display("FAIL reset_lives: got %0d want 0", lives); end
    total++; if (heart_en !== 3'b000) begin bad++; $display("FAIL reset_hearts: got %b want 000", heart_en); end
    total++; if (is_shielded !== 1'b0) begin bad++; $display("FAIL reset_shield: got %b want 0", is_shielded); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_over: got %b want 0", game_over); end
  endtask

  task automatic test_start;
    rst = 1'b1;
    @(negedge clk);
    total++; if (lives !== 3'd3) begin bad++; $display("FAIL start_lives: got %0d want 3", lives); end
    total++; if (heart_en !== 3'b111) begin bad++; $display("FAIL start_hearts: got %b want 111", heart_en); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL start_over: got %b want 0", game_over); end
  endtask

  task automatic test_hit;
    logic [2:0] exp_he;
    pulse(1, 0, 0);
    total++; if (lives !== 3'd2) begin bad++; $display("FAIL hit_lives: got %0d want 2", lives); end
    total++; if (heart_en !== 3'b011) begin bad++; $display("FAIL hit_hearts: got %b want 011", heart_en); end
    for (int t = 1; t <= 60; t++) begin
      tick_n(1);
      if (t == 7 || t == 8 || t == 15 || t == 16) begin
        exp_he = (BLINK && t >= 8 && t < 16) ? 3'b000 : 3'b011;
        total++;
        if (heart_en !== exp_he) begin bad++; $display("FAIL invuln_hearts_t%0d: got %b want %b", t, heart_en, exp_he); end
      end
      if (t == 10 || t == 59) begin
        pulse(1, 0, 0);
        total++; if (lives !== 3'd2) begin bad++; $display("FAIL invuln_hit_t%0d: got %0d want 2", t, lives); end
      end
    end
    total++; if (heart_en !== 3'b011) begin bad++; $display("FAIL invuln_exit_hearts: got %b want 011", heart_en); end
    pulse(1, 0, 0);
    total++; if (lives !== 3'd1) begin bad++; $display("FAIL second_hit: got %0d want 1", lives); end
    total++; if (heart_en !== 3'b001) begin bad++; $display("FAIL second_hit_hearts: got %b want 001", heart_en); end
  endtask

  task automatic test_restart;
    @(negedge clk) game_en = 1'b0;
    @(negedge clk);
    total++; if (lives !== 3'd0) begin bad++; $display("FAIL idle_lives: got %0d want 0", lives); end
    total++; if (heart_en !== 3'b000) begin bad++; $display("FAIL idle_hearts: got %b want 000", heart_en); end
    total++; if (game_over !== 1'b0 || is_shielded !== 1'b0) begin
      bad++; $display("FAIL idle_flags: got over=%b shield=%b want 0 0", game_over, is_shielded); end
    game_en = 1'b1;
    @(negedge clk);
    total++; if (lives !== 3'd3) begin bad++; $display("FAIL restart_lives: got %0d want 3", lives); end
  endtask

  task automatic test_death;
    tick_n(60);
    pulse(1, 0, 0);
    total++; if (lives !== 3'd0) begin bad++; $display("FAIL dead_lives: got %0d want 0", lives); end
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL dead_over: got %b want 1", game_over); end
    total++; if (heart_en !== 3'b000) begin bad++; $display("FAIL dead_hearts: got %b want 000", heart_en); end
    pulse(0, 1, 0);
    total++; if (lives !== 3'd0) begin bad++; $display("FAIL dead_heal: got %0d want 0", lives); end
    pulse(0, 0, 1);
    total++; if (is_shielded !== 1'b0 || game_over !== 1'b1) begin
      bad++; $display("FAIL dead_shield: got shield=%b over=%b want 0 1", is_shielded, game_over); end
    test_restart();
  endtask

  task automatic test_shield;
    pulse(0, 0, 1);
    total++; if (is_shielded !== 1'b1) begin bad++; $display("FAIL shield_on: got %b want 1", is_shielded); end
    pulse(1, 0, 0);
    total++; if (lives !== 3'd3) begin bad++; $display("FAIL shield_hit: got %0d want 3", lives); end
    tick_n(299);
    total++; if (is_shielded !== 1'b1) begin bad++; $display("FAIL shield_t299: got %b want 1", is_shielded); end
    pulse(0, 0, 1);
    tick_n(299);
    total++; if (is_shielded !== 1'b1) begin bad++; $display("FAIL shield_ext_299: got %b want 1", is_shielded); end
    tick_n(1);
    total++; if (is_shielded !== 1'b0) begin bad++; $display("FAIL shield_ext_300: got %b want 0", is_shielded); end
    total++; if (lives !== 3'd3) begin bad++; $display("FAIL shield_end_lives: got %0d want 3", lives); end
  endtask

  task automatic test_tick_pickup;
    pulse(0, 0, 1);
    tick_n(5);
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) begin vsync = 1'b1; shield_pickup = 1'b1; end
    @(negedge clk) shield_pickup = 1'b0;
    tick_n(299);
    total++; if (is_shielded !== 1'b1) begin bad++; $display("FAIL coincide_299: got %b want 1", is_shielded); end
    tick_n(1);
    total++; if (is_shielded !== 1'b0) begin bad++; $display("FAIL coincide_300: got %b want 0", is_shielded); end
  endtask

  task automatic test_pairs;
    pulse(0, 1, 0);
    total++; if (lives !== 3'd3) begin bad++; $display("FAIL heal_sat: got %0d want 3", lives); end
    pulse(1, 0, 1);
    total++; if (lives !== 3'd3 || is_shielded !== 1'b1) begin
      bad++; $display("FAIL hit_shield: got lives=%0d shield=%b want 3 1", lives, is_shielded); end
    test_restart();
    pulse(1, 1, 0);
    total++; if (lives !== 3'd3) begin bad++; $display("FAIL hit_heal: got %0d want 3", lives); end
    pulse(1, 0, 0);
    total++; if (lives !== 3'd3) begin bad++; $display("FAIL hit_heal_invuln: got %0d want 3", lives); end
    test_restart();
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    total++; if (lives !== 3'd3 || heart_en !== 3'b111) begin
      bad++; $display("FAIL invuln_heal: got lives=%0d hearts=%b want 3 111", lives, heart_en); end
    pulse(0, 0, 1);
    total++; if (is_shielded !== 1'b1) begin bad++; $display("FAIL invuln_shield: got %b want 1", is_shielded); end
  endtask

  task automatic test_async_reset;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if (lives !== 3'd0 || heart_en !== 3'b000) begin
      bad++; $display("FAIL async_rst_lives: got lives=%0d hearts=%b want 0 000", lives, heart_en); end
    total++; if (is_shielded !== 1'b0 || game_over !== 1'b0) begin
      bad++; $display("FAIL async_rst_flags: got shield=%b over=%b want 0 0", is_shielded, game_over); end
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit();
    test_death();
    test_shield();
    test_tick_pickup();
    test_pairs();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
